// File: rtl/dmem_bridge.sv
// Data-memory bridge: posts stores into an in-order write buffer, serialises loads
// behind them, and does big-endian byte-lane steering between the CPU and a req/ack memory.
module dmem_bridge #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [1:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        misalign,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_REQ  = 2'd1;
    localparam logic [1:0] S_RD_REQ  = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   buf_addr_q [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];
    logic [3:0]    buf_be_q   [DEPTH];

    logic          access, illegal, ld_ok, st_ok, full, push, pop;
    logic [31:0]   st_data, ld_data;
    logic [3:0]    st_be;
    logic [31:0]   word_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign access    = cpu_rd | cpu_wr;
    assign word_addr = {cpu_addr[31:2], 2'b00};

    always_comb begin
        illegal = (cpu_rd & cpu_wr)
                | (cpu_size == 2'b11)
                | ((cpu_size == 2'b01) & cpu_addr[0])
                | ((cpu_size == 2'b00) & (cpu_addr[1:0] != 2'b00));
    end

    assign ld_ok = cpu_rd & ~illegal;
    assign st_ok = cpu_wr & ~illegal;
    assign full  = (count_q == CNT_FULL);
    assign push  = reset & st_ok & ~full;

    // stall uses the registered count, so a pop in the same cycle never unstalls a store
    assign misalign = reset & access & illegal;
    assign stall    = reset & ((ld_ok & (state_q != S_RD_DONE)) | (st_ok & full));

    // Store steering: lane k is bits [31-8k -: 8], data replicated across lanes
    always_comb begin
        st_data = cpu_wdata;
        st_be   = 4'b1111;
        case (cpu_size)
            2'b01: begin
                st_data = {2{cpu_wdata[15:0]}};
                st_be   = cpu_addr[1] ? 4'b0011 : 4'b1100;
            end
            2'b10: begin
                st_data = {4{cpu_wdata[7:0]}};
                st_be   = 4'b1000 >> cpu_addr[1:0];
            end
            default: ;
        endcase
    end

    // Load extraction: right-aligned, zero-filled
    always_comb begin
        ld_data = m_rdata;
        case (cpu_size)
            2'b01: ld_data = cpu_addr[1] ? {16'b0, m_rdata[15:0]} : {16'b0, m_rdata[31:16]};
            2'b10: begin
                case (cpu_addr[1:0])
                    2'd0:    ld_data = {24'b0, m_rdata[31:24]};
                    2'd1:    ld_data = {24'b0, m_rdata[23:16]};
                    2'd2:    ld_data = {24'b0, m_rdata[15:8]};
                    default: ld_data = {24'b0, m_rdata[7:0]};
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        rdata_d   = rdata_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Buffered stores always win over a waiting load
                if (count_q != '0) begin
                    state_d   = S_WR_REQ;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b1;
                    m_addr_d  = buf_addr_q[rd_ptr_q];
                    m_wdata_d = buf_data_q[rd_ptr_q];
                    m_be_d    = buf_be_q[rd_ptr_q];
                end else if (ld_ok) begin
                    state_d   = S_RD_REQ;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = word_addr;
                    m_wdata_d = '0;
                    m_be_d    = 4'b1111;
                end
            end
            S_WR_REQ: begin
                if (m_ack) begin
                    pop     = 1'b1;
                    m_req_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (m_ack) begin
                    rdata_d = ld_data;
                    m_req_d = 1'b0;
                    state_d = S_RD_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            rdata_q   <= rdata_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= word_addr;
            buf_data_q[wr_ptr_q] <= st_data;
            buf_be_q[wr_ptr_q]   <= st_be;
        end
    end

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: a byte-level memory model predicts every bus
// transaction and every load result; a negedge monitor/responder checks them.
module tb_dmem_bridge;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [1:0]  cpu_size = '0;
    logic [31:0] cpu_rdata;
    logic        stall, misalign, m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    dmem_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_size(cpu_size), .cpu_rdata(cpu_rdata), .stall(stall), .misalign(misalign),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    int checks = 0, errors = 0;
    int fixed_delay = 0, cur_delay = 0, wcnt = 0;
    bit rand_delay = 0;
    txn_t        mon_t;
    logic [31:0] mon_w, mon_mask, mon_e;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] w;
        int k;
        w = ref_word({addr[31:2], 2'b00});
        k = int'(addr[1:0]);
        if (size == 2'd0) return w;
        if (size == 2'd1) return (k == 0) ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
        return {24'b0, w[31-8*k -: 8]};
    endfunction

    function automatic txn_t ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
        txn_t t;
        logic [31:0] w;
        int k;
        t.addr = {addr[31:2], 2'b00};
        t.we   = 1'b1;
        w = ref_word(t.addr);
        k = int'(addr[1:0]);
        if (size == 2'd0) begin
            w = d; t.be = 4'b1111;
        end else if (size == 2'd1) begin
            if (k == 0) begin w[31:16] = d[15:0]; t.be = 4'b1100; end
            else        begin w[15:0]  = d[15:0]; t.be = 4'b0011; end
        end else begin
            w[31-8*k -: 8] = d[7:0];
            t.be = 4'(1 << (3 - k));
        end
        ref_mem[t.addr] = w;
        t.data = w;
        return t;
    endfunction

    // Memory responder plus scoreboard monitor, all at negedge
    always @(negedge clk) begin
        if (!reset) begin
            m_ack = 1'b0;
            wcnt  = 0;
        end else if (m_req) begin
            if (wcnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
            m_ack = (wcnt >= cur_delay);
            mon_w = phys_mem.exists(m_addr) ? phys_mem[m_addr] : init_word(m_addr);
            m_rdata = mon_w;
            if (m_ack) begin
                wcnt = 0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", m_addr, 32'hFFFFFFFF);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("txn_addr", m_addr, mon_t.addr);
                    chk("txn_we", {31'b0, m_we}, {31'b0, mon_t.we});
                    chk("txn_be", {28'b0, m_be}, {28'b0, mon_t.be});
                    if (mon_t.we) begin
                        mon_mask = lane_mask(mon_t.be);
                        chk("txn_wdata", m_wdata & mon_mask, mon_t.data & mon_mask);
                    end
                end
                if (m_we) begin
                    mon_mask = lane_mask(m_be);
                    phys_mem[m_addr] = (mon_w & ~mon_mask) | (m_wdata & mon_mask);
                end
            end else begin
                wcnt++;
            end
        end else begin
            m_ack = 1'b0;
            wcnt  = 0;
        end

        if (reset && cpu_rd && !stall && !misalign) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_load_done", cpu_rdata, 32'hFFFFFFFF);
            end else begin
                mon_e = exp_rd.pop_front();
                chk("load_data", cpu_rdata, mon_e);
            end
        end
    end

    // Presents one CPU access, holds it while stalled, and records predictions
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] d, output int stalls);
        bit   ill;
        txn_t t;
        ill = (rd && wr) || (size == 2'd3) || (size == 2'd1 && addr[0])
            || (size == 2'd0 && addr[1:0] != 2'b00);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_size = size; cpu_wdata = d;
        if (!ill && rd) begin
            t.addr = {addr[31:2], 2'b00}; t.we = 1'b0; t.be = 4'b1111; t.data = '0;
            exp_q.push_back(t);
            exp_rd.push_back(ref_load(addr, size));
        end
        stalls = 0;
        while (1) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 300) begin
                chk("stall_timeout", 32'(stalls), 32'd0);
                break;
            end
        end
        if (rd || wr) chk("misalign", {31'b0, misalign}, {31'b0, ill});
        if (ill) chk("illegal_no_stall", 32'(stalls), 32'd0);
        if (!ill && wr) exp_q.push_back(ref_store(addr, size, d));
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_req) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s1, s2, s3, n, r;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd, wr;

        // Reset: a legal load held during reset must not stall
        cpu_rd = 1'b1; cpu_size = 2'd0; cpu_addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_be", {28'b0, m_be}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        cpu_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        fixed_delay = 0;
        access(0, 1, 32'h100, 2'd0, 32'hDEADBEEF, s);
        chk("store_no_stall", 32'(s), 32'd0);
        access(0, 1, 32'h203, 2'd2, 32'h000000AB, s);
        access(0, 1, 32'h202, 2'd1, 32'h00001234, s);
        drain();

        // Full buffer with slow memory
        fixed_delay = 3;
        access(0, 1, 32'h300, 2'd0, 32'h11111111, s1);
        access(0, 1, 32'h304, 2'd0, 32'h22222222, s2);
        access(0, 1, 32'h308, 2'd0, 32'h33333333, s3);
        chk("full_s1", 32'(s1), 32'd0);
        chk("full_s2", 32'(s2), 32'd0);
        chk("full_s3_stalls", {31'b0, s3 > 0}, 32'd1);
        drain();

        fixed_delay = 0;
        access(0, 1, 32'h10, 2'd0, 32'h11223344, s);
        access(1, 0, 32'h10, 2'd0, 32'h0, s);
        chk("ld_after_st", cpu_rdata, 32'h11223344);
        access(0, 1, 32'h40, 2'd0, 32'hA1B2C3D4, s);
        access(1, 0, 32'h41, 2'd2, 32'h0, s);
        chk("ld_byte", cpu_rdata, 32'h000000B2);
        access(1, 0, 32'h42, 2'd1, 32'h0, s);
        chk("ld_half", cpu_rdata, 32'h0000C3D4);
        chk("ld_latency", 32'(s), 32'd2);
        access(1, 0, 32'h42, 2'd0, 32'h0, s);
        @(negedge clk);
        chk("misalign_pulse_gone", {31'b0, misalign}, 32'd0);
        chk("misalign_no_req", {31'b0, m_req}, 32'd0);

        // Reset while a read is outstanding
        fixed_delay = 8;
        @(posedge clk); #1;
        cpu_rd = 1'b1; cpu_addr = 32'h80; cpu_size = 2'd0;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        chk("rd_req_up", {31'b0, m_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_mid_m_addr", m_addr, 32'd0);
        cpu_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Randomised traffic with random memory wait states
        rand_delay = 1;
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 99));
            wr = (r < 45) || (r >= 95);
            rd = (r >= 45) && (r < 95);
            if (r >= 90 && r < 95) wr = 1'b1;
            a  = 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 85) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            if ($urandom_range(0, 99) < 4) sz = 2'd3;
            access(rd, wr, a, sz, $urandom, s);
            if ($urandom_range(0, 9) == 0) begin
                repeat (int'($urandom_range(1, 4))) @(posedge clk);
                #1;
            end
        end
        drain();
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
